uart_program_loader: RTL

Receive-side consumer of the debug UART: takes the byte stream from `uart_rx` and runs the "load program" command (0x07). It reads an instruction count, packs each group of four little-endian bytes into a 32-bit instruction, and writes each instruction into MIPS instruction memory. When the load finishes it returns an ASCII acknowledge byte to `uart_tx`. The debug controller enables it only while the pipeline is halted.

---
 rtl/uart_program_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// ============================================================================
// Module   : uart_program_loader
// Purpose  : Runs the UART "load program" command. It packs little-endian bytes
//            into 32-bit words, writes them to instruction memory and returns
//            an ASCII reply byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_program_loader #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          MAX_INSTRUCTION = 64,
    parameter logic [7:0]  CMD_LOAD        = 8'h07,
    parameter int          TIMEOUT_CYCLES  = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_enable,
    input  logic                  i_tx_busy,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [7:0]            o_instr_count
);

    localparam int         TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] C_ACK_R = 8'h52;
    localparam logic [7:0] C_ACK_E = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTE  = 3'd2,
        S_WRITE = 3'd3,
        S_ACK   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_n, w_n_nxt;
    logic [6:0]            r_word_idx, w_word_idx_nxt;
    logic [1:0]            r_byte_idx, w_byte_idx_nxt;
    logic [31:0]           r_word, w_word_nxt;
    logic [TO_W-1:0]       r_to_cnt, w_to_cnt_nxt;
    logic [7:0]            r_tx_data, w_tx_data_nxt;
    logic                  r_tx_start, w_tx_start_nxt;
    logic                  r_imem_we, w_imem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_imem_addr, w_imem_addr_nxt;
    logic [31:0]           r_imem_data, w_imem_data_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_error, w_error_nxt;
    logic [7:0]            r_instr_count, w_instr_count_nxt;

    logic w_timeout;
    logic w_last_word;

    // Timeout fires after TIMEOUT_CYCLES consecutive cycles without a byte.
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_last_word = ({1'b0, r_word_idx} == (r_n - 8'd1));

    always_comb begin
        w_state_nxt       = r_state;
        w_n_nxt           = r_n;
        w_word_idx_nxt    = r_word_idx;
        w_byte_idx_nxt    = r_byte_idx;
        w_word_nxt        = r_word;
        w_to_cnt_nxt      = r_to_cnt;
        w_tx_data_nxt     = r_tx_data;
        w_tx_start_nxt    = 1'b0;
        w_imem_we_nxt     = 1'b0;
        w_imem_addr_nxt   = r_imem_addr;
        w_imem_data_nxt   = r_imem_data;
        w_done_nxt        = 1'b0;
        w_error_nxt       = 1'b0;
        w_instr_count_nxt = r_instr_count;

        case (r_state)
            S_IDLE: begin
                w_to_cnt_nxt = '0;
                if (i_rx_valid && i_enable && (i_rx_data == CMD_LOAD)) begin
                    w_state_nxt       = S_COUNT;
                    w_instr_count_nxt = 8'd0;
                end
            end
            S_COUNT: begin
                if (i_rx_valid) begin
                    w_n_nxt      = i_rx_data;
                    w_to_cnt_nxt = '0;
                    if (i_rx_data == 8'd0) begin
                        w_state_nxt = S_ACK;
                    end else if (int'(i_rx_data) > MAX_INSTRUCTION) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_word_idx_nxt = 7'd0;
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = S_BYTE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_BYTE: begin
                if (i_rx_valid) begin
                    w_to_cnt_nxt = '0;
                    w_word_nxt[8*r_byte_idx +: 8] = i_rx_data;
                    if (r_byte_idx == 2'd3) begin
                        // Outputs are registered, so the strobe is loaded on entry to WRITE.
                        w_state_nxt       = S_WRITE;
                        w_imem_we_nxt     = 1'b1;
                        w_imem_addr_nxt   = ADDR_WIDTH'({r_word_idx, 2'b00});
                        w_imem_data_nxt   = {i_rx_data, r_word[23:0]};
                        w_instr_count_nxt = {1'b0, r_word_idx} + 8'd1;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_WRITE: begin
                w_word_idx_nxt = r_word_idx + 7'd1;
                w_byte_idx_nxt = 2'd0;
                w_to_cnt_nxt   = '0;
                if (w_last_word) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_BYTE;
                    if (i_rx_valid) begin
                        w_word_nxt[7:0] = i_rx_data;
                        w_byte_idx_nxt  = 2'd1;
                    end
                end
            end
            S_ACK: begin
                if (!i_tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = C_ACK_R;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_ERR: begin
                if (!i_tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = C_ACK_E;
                    w_error_nxt    = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_n           <= 8'd0;
            r_word_idx    <= 7'd0;
            r_byte_idx    <= 2'd0;
            r_word        <= 32'd0;
            r_to_cnt      <= '0;
            r_tx_data     <= 8'd0;
            r_tx_start    <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_data   <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_instr_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_n           <= w_n_nxt;
            r_word_idx    <= w_word_idx_nxt;
            r_byte_idx    <= w_byte_idx_nxt;
            r_word        <= w_word_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_imem_we     <= w_imem_we_nxt;
            r_imem_addr   <= w_imem_addr_nxt;
            r_imem_data   <= w_imem_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_error       <= w_error_nxt;
            r_instr_count <= w_instr_count_nxt;
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_start    = r_tx_start;
    assign o_imem_we     = r_imem_we;
    assign o_imem_addr   = r_imem_addr;
    assign o_imem_data   = r_imem_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_instr_count = r_instr_count;

endmodule

`default_nettype wire
